// File: rtl/qspi_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : qspi_shift_engine_if
// Description : Transfer-request / completion bus of the QSPI shift engine.
//               The requester drives the transfer descriptor (load_i, data_i,
//               num_bits_i, xspi_i, dir_i, cs_hold_i) and abort_i. The engine
//               returns ready_o, done_o and rx_data_o.
//               Modports: master = requester side, slave = engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface qspi_shift_engine_if;
    logic        load_i;      // transfer request
    logic [31:0] data_i;      // TX word, right-aligned
    logic [5:0]  num_bits_i;  // bits to shift (values above 32 act as 32)
    logic [1:0]  xspi_i;      // 00 single, 01 dual, 10 quad, 11 single
    logic        dir_i;       // 0 TX, 1 RX
    logic        cs_hold_i;   // keep CS asserted after this transfer
    logic        abort_i;     // cancel whatever is in progress
    logic        ready_o;     // engine idle, load accepted
    logic        done_o;      // one-cycle completion pulse
    logic [31:0] rx_data_o;   // received bits, right-aligned

    modport master (
        output load_i, data_i, num_bits_i, xspi_i, dir_i, cs_hold_i, abort_i,
        input  ready_o, done_o, rx_data_o
    );

    modport slave (
        input  load_i, data_i, num_bits_i, xspi_i, dir_i, cs_hold_i, abort_i,
        output ready_o, done_o, rx_data_o
    );
endinterface
`default_nettype wire

// File: rtl/qspi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : qspi_shift_engine
// Description : Single/dual/quad SPI shift engine, SPI mode 0. Accepts one
//               transfer descriptor at a time, shifts it MSB-first over 1, 2
//               or 4 lanes with SCLK = clk_i / (2*CLK_DIV), and reports
//               completion with a one-cycle done pulse.
// Parameters  : CLK_DIV - clk_i cycles per SCLK half-period (1..255)
// Ports       : clk_i, rst_n_i  - clock, asynchronous active-low reset
//               bus (slave)     - transfer request / completion bus
//               sclk_o, cs_n_o  - SPI clock and chip select
//               io_o, io_oe_o   - lane data out and output enables
//               io_i            - lane data in
// Config      : QSPI_SHIFT_QUAD_EN - when defined, xspi_i=10 selects quad
//               lanes; otherwise it falls back to single and lanes 3:2 are
//               tied off.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  wire                clk_i,
    input  wire                rst_n_i,
    qspi_shift_engine_if.slave bus,
    output logic               sclk_o,
    output logic               cs_n_o,
    output logic [3:0]         io_o,
    output logic [3:0]         io_oe_o,
    input  wire  [3:0]         io_i
);

    localparam logic [7:0] c_div_last    = 8'(CLK_DIV - 1);
    localparam logic [1:0] c_lane_single = 2'd0;
    localparam logic [1:0] c_lane_dual   = 2'd1;
    localparam logic [1:0] c_lane_quad   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] shreg_q,   shreg_d;    // TX bits still to send, left-aligned
    logic [31:0] rxsh_q,    rxsh_d;     // RX shift register
    logic [31:0] rx_data_q, rx_data_d;
    logic [5:0]  nbits_q,   nbits_d;
    logic [5:0]  beats_q,   beats_d;    // beats left including current one
    logic [7:0]  div_q,     div_d;
    logic [1:0]  lanes_q,   lanes_d;
    logic        dir_q,     dir_d;
    logic        hold_q,    hold_d;
    logic        sclk_q,    sclk_d;
    logic        cs_n_q,    cs_n_d;
    logic [3:0]  io_q,      io_d;
    logic [3:0]  oe_q,      oe_d;

    logic [5:0]  w_nbits;
    logic [1:0]  w_lanes;
    logic [5:0]  w_beats;
    logic [31:0] w_align;
    logic [31:0] w_rx_next;
    logic [31:0] w_rx_mask;
    logic [3:0]  w_io_in;

    // Next lane bits come from the top of the left-aligned shift register,
    // so the higher-numbered bit lands on the higher-numbered lane.
    function automatic logic [3:0] beat_out(input logic [31:0] s, input logic [1:0] lanes);
        case (lanes)
            c_lane_dual: beat_out = {2'b00, s[31:30]};
            c_lane_quad: beat_out = s[31:28];
            default:     beat_out = {3'b000, s[31]};
        endcase
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] s, input logic [1:0] lanes);
        case (lanes)
            c_lane_dual: shift_out = {s[29:0], 2'b00};
            c_lane_quad: shift_out = {s[27:0], 4'b0000};
            default:     shift_out = {s[30:0], 1'b0};
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lanes);
        case (lanes)
            c_lane_dual: lane_mask = 4'b0011;
            c_lane_quad: lane_mask = 4'b1111;
            default:     lane_mask = 4'b0001;
        endcase
    endfunction

`ifdef QSPI_SHIFT_QUAD_EN
    assign w_io_in = io_i;
    assign io_o    = io_q;
    assign io_oe_o = oe_q;
`else
    // Upper lanes are not part of this build; their register bits never leave 0.
    logic [5:0] unused_hi_lanes;
    assign unused_hi_lanes = {io_i[3:2], io_q[3:2], oe_q[3:2]};
    assign w_io_in = {2'b00, io_i[1:0]};
    assign io_o    = {2'b00, io_q[1:0]};
    assign io_oe_o = {2'b00, oe_q[1:0]};
`endif

    always_comb begin
        w_lanes = c_lane_single;
        case (bus.xspi_i)
            2'b01:   w_lanes = c_lane_dual;
`ifdef QSPI_SHIFT_QUAD_EN
            2'b10:   w_lanes = c_lane_quad;
`endif
            default: w_lanes = c_lane_single;
        endcase
    end

    assign w_nbits = (bus.num_bits_i > 6'd32) ? 6'd32 : bus.num_bits_i;

    always_comb begin
        case (w_lanes)
            c_lane_dual: w_beats = 6'((7'(w_nbits) + 7'd1) >> 1);
            c_lane_quad: w_beats = 6'((7'(w_nbits) + 7'd3) >> 2);
            default:     w_beats = w_nbits;
        endcase
    end

    // Left-align the TX word so bit num_bits-1 sits at bit 31; trailing pad
    // zeros then fall out of the shift register naturally.
    assign w_align = bus.data_i << (6'd32 - w_nbits);

    always_comb begin
        case (lanes_q)
            c_lane_dual: w_rx_next = {rxsh_q[29:0], w_io_in[1:0]};
            c_lane_quad: w_rx_next = {rxsh_q[27:0], w_io_in};
            default:     w_rx_next = {rxsh_q[30:0], w_io_in[1]};
        endcase
    end

    assign w_rx_mask = (nbits_q == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << nbits_q) - 32'd1);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rxsh_d    = rxsh_q;
        rx_data_d = rx_data_q;
        nbits_d   = nbits_q;
        beats_d   = beats_q;
        div_d     = div_q;
        lanes_d   = lanes_q;
        dir_d     = dir_q;
        hold_d    = hold_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        io_d      = io_q;
        oe_d      = oe_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_i) begin
                    nbits_d   = w_nbits;
                    lanes_d   = w_lanes;
                    dir_d     = bus.dir_i;
                    hold_d    = bus.cs_hold_i;
                    rx_data_d = 32'd0;
                    rxsh_d    = 32'd0;
                    div_d     = 8'd0;
                    sclk_d    = 1'b0;
                    if (w_nbits == 6'd0) begin
                        // Empty transfer: complete without touching the bus.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        cs_n_d  = 1'b0;
                        beats_d = w_beats;
                        shreg_d = shift_out(w_align, w_lanes);
                        io_d    = bus.dir_i ? 4'd0 : beat_out(w_align, w_lanes);
                        oe_d    = bus.dir_i ? 4'd0 : lane_mask(w_lanes);
                    end
                end
            end

            ST_SHIFT: begin
                if (div_q == c_div_last) begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: receiver samples here.
                        sclk_d = 1'b1;
                        if (dir_q) begin
                            rxsh_d = w_rx_next;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (beats_q == 6'd1) begin
                            state_d = ST_DONE;
                            cs_n_d  = ~hold_q;
                            io_d    = 4'd0;
                            oe_d    = 4'd0;
                            if (dir_q) begin
                                rx_data_d = rxsh_q & w_rx_mask;
                            end
                        end else begin
                            beats_d = beats_q - 6'd1;
                            shreg_d = shift_out(shreg_q, lanes_q);
                            io_d    = dir_q ? 4'd0 : beat_out(shreg_q, lanes_q);
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a simultaneous load.
        if (bus.abort_i) begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            io_d    = 4'd0;
            oe_d    = 4'd0;
            div_d   = 8'd0;
            beats_d = 6'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            shreg_q   <= 32'd0;
            rxsh_q    <= 32'd0;
            rx_data_q <= 32'd0;
            nbits_q   <= 6'd0;
            beats_q   <= 6'd0;
            div_q     <= 8'd0;
            lanes_q   <= c_lane_single;
            dir_q     <= 1'b0;
            hold_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            io_q      <= 4'd0;
            oe_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rxsh_q    <= rxsh_d;
            rx_data_q <= rx_data_d;
            nbits_q   <= nbits_d;
            beats_q   <= beats_d;
            div_q     <= div_d;
            lanes_q   <= lanes_d;
            dir_q     <= dir_d;
            hold_q    <= hold_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            io_q      <= io_d;
            oe_q      <= oe_d;
        end
    end

    assign sclk_o        = sclk_q;
    assign cs_n_o        = cs_n_q;
    assign bus.ready_o   = (state_q == ST_IDLE);
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.rx_data_o = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_shift_engine
// Description : Self-checking bench for qspi_shift_engine (CLK_DIV = 2).
//               Directed vector table, hand-written hold/abort/reset
//               sequences and randomized transfers, all compared against a
//               bit-level reference model of the SPI transfer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_shift_engine;

    localparam int CD = 2;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       sclk_o, cs_n_o;
    logic [3:0] io_o, io_oe_o;
    logic [3:0] io_i;

    int errors = 0;
    int checks = 0;

    qspi_shift_engine_if bus();

    qspi_shift_engine #(.CLK_DIV(CD)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus),
        .sclk_o  (sclk_o),
        .cs_n_o  (cs_n_o),
        .io_o    (io_o),
        .io_oe_o (io_oe_o),
        .io_i    (io_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int lanes_of(input logic [1:0] xs);
        if (xs == 2'b01) return 2;
`ifdef QSPI_SHIFT_QUAD_EN
        if (xs == 2'b10) return 4;
`endif
        return 1;
    endfunction

    // Lane j of beat k carries data bit n-1-(k*L + L-1-j); negative index is pad.
    function automatic logic [3:0] tx_beat(input logic [31:0] d, input int n, input int L, input int k);
        logic [3:0] v;
        int idx;
        v = 4'd0;
        for (int j = 0; j < L; j++) begin
            idx = n - 1 - (k * L + (L - 1 - j));
            if (idx >= 0) v[j] = d[idx];
        end
        return v;
    endfunction

    // Stream bit s (MSB of rxin first) is presented on the lane it belongs to;
    // lanes the engine must ignore get random junk.
    function automatic logic [3:0] rx_drive(input logic [31:0] rxin, input int L, input int k);
        logic [3:0] v;
        int s, lane;
        v = 4'($urandom);
        for (int m = 0; m < L; m++) begin
            s    = k * L + m;
            lane = (L == 1) ? 1 : (L - 1 - m);
            v[lane] = (s < 32) ? rxin[31 - s] : 1'b0;
        end
        return v;
    endfunction

    task automatic run_xfer(
        input  string       tag,
        input  logic [31:0] data,
        input  logic [5:0]  nb,
        input  logic [1:0]  xs,
        input  logic        dir,
        input  logic        hold,
        input  logic [31:0] rxin,
        output int          lat_o,
        output logic [63:0] io_seq_o,
        output logic [31:0] rx_o,
        output logic        cs_o
    );
        int n, L, B, T, i, exp_lat;
        int bad_sclk, bad_io, bad_oe, bad_cs;
        logic [63:0] raw;
        logic [31:0] exp_rx;
        logic [3:0]  exp_oe;
        logic        cs_before, exp_cs, done_seen;

        n       = (nb > 6'd32) ? 32 : int'(nb);
        L       = lanes_of(xs);
        B       = (n + L - 1) / L;
        T       = B * L;
        exp_lat = (n == 0) ? 0 : 2 * CD * B;
        raw     = (T == 0) ? 64'd0 : ({32'd0, rxin} >> (32 - T));
        exp_rx  = (dir && n > 0) ? 32'(raw & ((64'd1 << n) - 64'd1)) : 32'd0;
        exp_oe  = dir ? 4'b0000 : ((L == 1) ? 4'b0001 : (L == 2) ? 4'b0011 : 4'b1111);
        cs_before = cs_n_o;
        exp_cs  = (n == 0) ? cs_before : ~hold;

        bus.data_i     = data;
        bus.num_bits_i = nb;
        bus.xspi_i     = xs;
        bus.dir_i      = dir;
        bus.cs_hold_i  = hold;
        bus.load_i     = 1'b1;
        io_i           = rx_drive(rxin, L, 0);
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;

        i = 0; done_seen = 1'b0; lat_o = -1; io_seq_o = 64'd0;
        bad_sclk = 0; bad_io = 0; bad_oe = 0; bad_cs = 0;
        while (i <= exp_lat + 8 && !done_seen) begin
            if (bus.done_o === 1'b1) begin
                done_seen = 1'b1;
                lat_o     = i;
            end else begin
                if (sclk_o !== ((i % (2 * CD)) >= CD)) bad_sclk++;
                if (io_oe_o !== exp_oe) bad_oe++;
                if (cs_n_o !== 1'b0) bad_cs++;
                if (!dir && io_o !== tx_beat(data, n, L, i / (2 * CD))) bad_io++;
                if (i % (2 * CD) == 0) io_seq_o = {io_seq_o[59:0], io_o};
                io_i = rx_drive(rxin, L, (i + 1) / (2 * CD));
                i++;
                @(posedge clk_i); #1;
            end
        end

        check({tag, " done_latency"}, 64'(lat_o), 64'(exp_lat));
        if (n > 0) begin
            check({tag, " sclk_trace"}, 64'(bad_sclk), 64'd0);
            check({tag, " oe_trace"},   64'(bad_oe),   64'd0);
            check({tag, " cs_low"},     64'(bad_cs),   64'd0);
            if (!dir) check({tag, " io_trace"}, 64'(bad_io), 64'd0);
        end
        rx_o = bus.rx_data_o;
        cs_o = cs_n_o;
        check({tag, " rx_data"},     64'(rx_o), 64'(exp_rx));
        check({tag, " cs_at_done"},  64'(cs_o), 64'(exp_cs));
        check({tag, " bus_at_done"}, 64'({sclk_o, io_oe_o}), 64'd0);
        @(posedge clk_i); #1;
        check({tag, " idle_after"}, 64'({bus.ready_o, bus.done_o, cs_n_o}), 64'({1'b1, 1'b0, exp_cs}));
    endtask

    typedef struct {
        logic [31:0] data;
        logic [5:0]  nb;
        logic [1:0]  xs;
        logic        dir;
        logic        hold;
        logic [31:0] rxin;
        int          exp_lat;
        logic [63:0] exp_io;
        logic [31:0] exp_rx;
        logic        exp_cs;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int          lat, dones, highs;
        logic [63:0] io_seq;
        logic [31:0] rx;
        logic        cs;

        rst_n_i = 1'b0;
        io_i = 4'd0;
        bus.load_i = 1'b0; bus.data_i = 32'd0; bus.num_bits_i = 6'd0; bus.xspi_i = 2'd0;
        bus.dir_i = 1'b0; bus.cs_hold_i = 1'b0; bus.abort_i = 1'b0;

        repeat (3) @(posedge clk_i); #1;
        check("reset_ready",  64'(bus.ready_o),   64'd1);
        check("reset_done",   64'(bus.done_o),    64'd0);
        check("reset_rx",     64'(bus.rx_data_o), 64'd0);
        check("reset_pins",   64'({sclk_o, cs_n_o, io_o, io_oe_o}), 64'({1'b0, 1'b1, 4'd0, 4'd0}));
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // data, nb, xs, dir, hold, rxin, exp_lat, exp_io (last 16 beats), exp_rx, exp_cs
        vecs[0] = '{32'h9F, 6'd8, 2'b00, 1'b0, 1'b0, 32'h0, 32, 64'h10011111, 32'h0, 1'b1};
`ifdef QSPI_SHIFT_QUAD_EN
        vecs[1] = '{32'h0, 6'd32, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, 32, 64'h0, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{32'hA5, 6'd8, 2'b10, 1'b0, 1'b0, 32'h0, 8, 64'hA5, 32'h0, 1'b1};
`else
        vecs[1] = '{32'h0, 6'd32, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, 128, 64'h0, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{32'hA5, 6'd8, 2'b10, 1'b0, 1'b0, 32'h0, 32, 64'h10100101, 32'h0, 1'b1};
`endif
        vecs[2] = '{32'h15, 6'd5, 2'b01, 1'b0, 1'b0, 32'h0, 12, 64'h222, 32'h0, 1'b1};
        vecs[4] = '{32'hFFFF, 6'd0, 2'b00, 1'b0, 1'b0, 32'h0, 0, 64'h0, 32'h0, 1'b1};
        vecs[5] = '{32'h80000001, 6'd40, 2'b00, 1'b0, 1'b0, 32'h0, 128, 64'h1, 32'h0, 1'b1};
        vecs[6] = '{32'h0, 6'd7, 2'b01, 1'b1, 1'b0, 32'hB4000000, 16, 64'h0, 32'h34, 1'b1};
        vecs[7] = '{32'h0, 6'd12, 2'b00, 1'b1, 1'b0, 32'hABC12345, 48, 64'h0, 32'hABC, 1'b1};

        for (int v = 0; v < 8; v++) begin
            run_xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].nb, vecs[v].xs, vecs[v].dir,
                     vecs[v].hold, vecs[v].rxin, lat, io_seq, rx, cs);
            check($sformatf("vec%0d table_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
            check($sformatf("vec%0d table_rx", v), 64'(rx), 64'(vecs[v].exp_rx));
            check($sformatf("vec%0d table_cs", v), 64'(cs), 64'(vecs[v].exp_cs));
            if (!vecs[v].dir) check($sformatf("vec%0d table_io", v), io_seq, vecs[v].exp_io);
        end

        // CS held across two transfers, with an empty transfer in between.
        run_xfer("hold1", 32'hA5, 6'd8, 2'b00, 1'b0, 1'b1, 32'h0, lat, io_seq, rx, cs);
        highs = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (cs_n_o !== 1'b0) highs++;
        end
        check("hold_gap_cs", 64'(highs), 64'd0);
        run_xfer("hold_empty", 32'h0, 6'd0, 2'b00, 1'b0, 1'b0, 32'h0, lat, io_seq, rx, cs);
        run_xfer("hold2", 32'h123456, 6'd24, 2'b00, 1'b0, 1'b0, 32'h0, lat, io_seq, rx, cs);

        // Abort during the low half of beat 3 of an 8-beat transfer.
        bus.data_i = 32'hFF; bus.num_bits_i = 6'd8; bus.xspi_i = 2'b00; bus.dir_i = 1'b0;
        bus.cs_hold_i = 1'b0; bus.load_i = 1'b1;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        repeat (9) @(posedge clk_i); #1;
        bus.abort_i = 1'b1;
        @(posedge clk_i); #1;
        bus.abort_i = 1'b0;
        check("abort_state", 64'({cs_n_o, sclk_o, bus.ready_o, io_oe_o, bus.done_o}),
              64'({1'b1, 1'b0, 1'b1, 4'd0, 1'b0}));
        dones = 0; highs = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (bus.done_o === 1'b1) dones++;
            if (sclk_o !== 1'b0) highs++;
        end
        check("abort_quiet", 64'({dones[15:0], highs[15:0]}), 64'd0);

        // Abort and load in the same cycle: abort wins, nothing starts.
        bus.load_i = 1'b1; bus.abort_i = 1'b1;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0; bus.abort_i = 1'b0;
        check("abort_over_load", 64'({bus.ready_o, cs_n_o, sclk_o}), 64'({1'b1, 1'b1, 1'b0}));

        // Reset in the middle of a transfer discards it.
        bus.num_bits_i = 6'd16; bus.load_i = 1'b1;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("midreset_out", 64'({bus.ready_o, bus.done_o, sclk_o, cs_n_o, io_o, io_oe_o}),
              64'({1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0}));
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        dones = 0;
        repeat (80) begin
            @(posedge clk_i); #1;
            if (bus.done_o === 1'b1) dones++;
        end
        check("midreset_no_done", 64'(dones), 64'd0);

        // Randomized transfers against the model.
        for (int r = 0; r < 24; r++) begin
            run_xfer($sformatf("rnd%0d", r), $urandom, 6'($urandom_range(0, 40)), 2'($urandom),
                     1'($urandom), 1'($urandom), $urandom, lat, io_seq, rx, cs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qspi_shift_engine.md
QSPI_SHIFT_ENGINE -- requirements
Module: qspi_shift_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk_i cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have ports clk_i in 1 system clock; rst_n_i in 1 asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-003 SHALL have load_i in 1 transfer request; data_i in 32 TX word, right-aligned; num_bits_i in 6 bits to shift, 0..32; xspi_i in 2 lanes (00 single, 01 dual, 10 quad, 11 treated as single); dir_i in 1 (0 TX, 1 RX); cs_hold_i in 1 keep CS asserted after transfer; abort_i in 1 cancel.
REQ-004 SHALL have ready_o out 1 accepting load; done_o out 1 one-cycle completion pulse; rx_data_o out 32 received bits, right-aligned.
REQ-005 SHALL have sclk_o out 1; cs_n_o out 1; io_o out 4; io_oe_o out 4; io_i in 4.

Function
REQ-006 SHALL implement states IDLE, SHIFT, DONE; ready_o=1 only in IDLE.
REQ-007 SHALL accept a transfer on a clk_i edge with load_i=1 and ready_o=1; latch data_i, num_bits_i (>32 clamped to 32), xspi_i, dir_i, cs_hold_i; load_i ignored outside IDLE.
REQ-008 num_bits_i=0: SHALL go IDLE->DONE, no SCLK edge, cs_n_o unchanged, done_o pulses, rx_data_o=0.
REQ-009 Lanes L=1/2/4; beats B=ceil(num_bits/L); TX bits MSB-first from bit num_bits-1, higher bit on higher lane; missing trailing bits padded 0.
REQ-010 In SHIFT, each beat: sclk_o=0 for CLK_DIV cycles then 1 for CLK_DIV cycles (SPI mode 0); io_o updated only at beat start.
REQ-011 RX SHALL sample io_i (single: io_i[1]; dual: io_i[1:0]; quad: io_i[3:0]) on the clk_i edge at which sclk_o goes 0->1, shifting left into a register; rx_data_o holds the lower num_bits bits, upper bits 0, stable until next accept.
REQ-012 io_oe_o: TX single 0001, dual 0011, quad 1111, asserted from accept through SHIFT; RX and IDLE/DONE 0000.
REQ-013 cs_n_o SHALL go 0 at the accepting edge; SHIFT->DONE after exactly 2*CLK_DIV*B cycles; done_o=1 during DONE (one cycle), then IDLE.
REQ-014 On DONE entry cs_n_o SHALL return 1 unless latched cs_hold=1, in which case it stays 0 through IDLE until a later transfer completes with cs_hold=0 or abort_i.
REQ-015 abort_i=1 in any state SHALL force IDLE next edge: cs_n_o=1, sclk_o=0, io_oe_o=0, no done_o; abort_i has priority over load_i.
REQ-016 sclk_o SHALL be 0 whenever not in SHIFT.

Reset
REQ-017 While rst_n_i=0: state IDLE, ready_o=1, done_o=0, rx_data_o=0, sclk_o=0, cs_n_o=1, io_o=0, io_oe_o=0, counters 0; reset mid-transfer SHALL discard it without done_o.

Configuration
REQ-018 With QSPI_SHIFT_QUAD_EN defined, quad mode SHALL operate per REQ-009..012.
REQ-019 Without QSPI_SHIFT_QUAD_EN, xspi_i=10 SHALL be treated as single, io_oe_o[3:2] and io_o[3:2] tied 0, io_i[3:2] unused.

Verification
REQ-020 CLK_DIV=2, TX single, data_i=0x9F, num_bits_i=8 -> io_o[0] sequence 1,0,0,1,1,1,1,1; 8 SCLK pulses; done_o 32 cycles after accept; cs_n_o=1 after.
REQ-021 RX quad, num_bits_i=32, io_i nibbles 0xD,0xE,0xA,0xD,0xB,0xE,0xE,0xF -> rx_data_o=0xDEADBEEF, io_oe_o=0000 throughout, 8 beats.
REQ-022 TX dual, num_bits_i=5, data_i=0x15 -> 3 beats, io_o[1:0]=10,10,10 (pad 0); done_o after 2*CLK_DIV*3 cycles.
REQ-023 cs_hold_i=1 8-bit TX then 24-bit TX with cs_hold_i=0 -> cs_n_o low continuously across both, high after second done_o.
REQ-024 abort_i mid-beat 3 of 8 -> next cycle cs_n_o=1, sclk_o=0, ready_o=1, no done_o; num_bits_i=0 -> done_o next cycle, no SCLK.
REQ-025 Without QSPI_SHIFT_QUAD_EN, xspi_i=10 TX 8 bits -> 8 single-lane beats, io_oe_o=0001.
